// File: rtl/sha256_round_sequencer.sv
// SHA-256 round sequencer: accepts one padded 512-bit block, drives the compressor's
// init/round/digest strobes and expands the message schedule in a 16-word sliding buffer.
module sha256_round_sequencer (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [511:0] block_data,
    input  logic         block_first,
    input  logic         block_last,
    output logic         init_round,
    output logic         init_digest,
    output logic         first_block,
    output logic         partial_rounds,
    output logic         update_digest,
    output logic [31:0]  w_data,
    output logic [5:0]   round_idx,
    input  logic         update_AH,
    input  logic         update_H,
    output logic         digest_valid,
    output logic         seq_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_ROUNDS = 3'd2,
        S_DIGEST = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] sched_r [16];
    logic [5:0]  t_r;
    logic        first_r;
    logic        last_r;
    logic        seq_error_r;
    logic        ack_miss_s;
    logic [31:0] w_next_s;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'd0, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // Next schedule word, entering the buffer 16 rounds ahead of its use.
    assign w_next_s = sigma1(sched_r[14]) + sched_r[9] + sigma0(sched_r[1]) + sched_r[0];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (block_valid) next_state_s = S_INIT;
                else             next_state_s = S_IDLE;
            end
            S_INIT:   next_state_s = S_ROUNDS;
            S_ROUNDS: begin
                if (t_r == 6'd63) next_state_s = S_DIGEST;
                else              next_state_s = S_ROUNDS;
            end
            S_DIGEST: begin
                if (last_r) next_state_s = S_DONE;
                else        next_state_s = S_IDLE;
            end
            S_DONE:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        block_ready    = 1'b0;
        init_round     = 1'b0;
        init_digest    = 1'b0;
        partial_rounds = 1'b0;
        update_digest  = 1'b0;
        digest_valid   = 1'b0;
        w_data         = 32'd0;
        round_idx      = 6'd0;
        case (state_r)
            S_IDLE: block_ready = 1'b1;
            S_INIT: begin
                init_round  = 1'b1;
                init_digest = 1'b1;
            end
            S_ROUNDS: begin
                partial_rounds = 1'b1;
                w_data         = sched_r[0];
                round_idx      = t_r;
            end
            S_DIGEST: update_digest = 1'b1;
            S_DONE:   digest_valid  = 1'b1;
            default:  block_ready   = 1'b0;
        endcase
    end

    // Missing acknowledgement detection for the checked states.
    always_comb begin
        ack_miss_s = 1'b0;
        case (state_r)
            S_INIT:   ack_miss_s = !update_AH || !update_H;
            S_ROUNDS: ack_miss_s = !update_AH;
            S_DIGEST: ack_miss_s = !update_H;
            default:  ack_miss_s = 1'b0;
        endcase
    end

    // Schedule buffer, round counter and captured block flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) sched_r[i] <= 32'd0;
            t_r     <= 6'd0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (block_valid) begin
                        for (int i = 0; i < 16; i++) sched_r[i] <= block_data[511 - 32*i -: 32];
                        t_r     <= 6'd0;
                        first_r <= block_first;
                        last_r  <= block_last;
                    end
                end
                S_ROUNDS: begin
                    for (int i = 0; i < 15; i++) sched_r[i] <= sched_r[i+1];
                    sched_r[15] <= w_next_s;
                    t_r         <= t_r + 6'd1;
                end
                default: t_r <= t_r;
            endcase
        end
    end

    // Sticky acknowledgement error; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_error_r <= 1'b0;
        end else if (ack_miss_s) begin
            seq_error_r <= 1'b1;
        end else begin
            seq_error_r <= seq_error_r;
        end
    end

    assign first_block = first_r;
    assign seq_error   = seq_error_r;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Randomized bench for sha256_round_sequencer against a cycle-count model of the block
// timeline and a plain-array SHA-256 message schedule.
module tb_sha256_round_sequencer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         block_valid = 1'b0;
    logic         block_ready;
    logic [511:0] block_data = 512'd0;
    logic         block_first = 1'b0;
    logic         block_last = 1'b0;
    logic         init_round, init_digest, first_block, partial_rounds, update_digest;
    logic [31:0]  w_data;
    logic [5:0]   round_idx;
    logic         update_AH = 1'b1;
    logic         update_H = 1'b1;
    logic         digest_valid;
    logic         seq_error;

    int vectors = 0;
    int errors = 0;
    int dv_count = 0;

    // Model state: m_cyc = cycles since the accept edge (0 = idle).
    int           m_cyc = 0;
    logic [511:0] m_block = 512'd0;
    logic         m_first = 1'b0;
    logic         m_last = 1'b0;
    logic         m_err = 1'b0;

    sha256_round_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .block_valid(block_valid), .block_ready(block_ready), .block_data(block_data),
        .block_first(block_first), .block_last(block_last),
        .init_round(init_round), .init_digest(init_digest), .first_block(first_block),
        .partial_rounds(partial_rounds), .update_digest(update_digest),
        .w_data(w_data), .round_idx(round_idx),
        .update_AH(update_AH), .update_H(update_H),
        .digest_valid(digest_valid), .seq_error(seq_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] w_of(input logic [511:0] blk, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        return w[t];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference timeline: accept, INIT, 64 rounds, DIGEST, DONE for last blocks.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc <= 0; m_block <= 512'd0; m_first <= 1'b0; m_last <= 1'b0; m_err <= 1'b0;
        end else if (m_cyc == 0) begin
            if (block_valid) begin
                m_cyc <= 1; m_block <= block_data; m_first <= block_first; m_last <= block_last;
            end
        end else begin
            if ((m_cyc >= 1 && m_cyc <= 65 && !update_AH) || ((m_cyc == 1 || m_cyc == 66) && !update_H))
                m_err <= 1'b1;
            if ((m_cyc == 66 && !m_last) || m_cyc == 67) m_cyc <= 0;
            else m_cyc <= m_cyc + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic rnd;
        rnd = (m_cyc >= 2 && m_cyc <= 65);
        chk("block_ready",    {31'd0, block_ready},    {31'd0, m_cyc == 0});
        chk("init_round",     {31'd0, init_round},     {31'd0, m_cyc == 1});
        chk("init_digest",    {31'd0, init_digest},    {31'd0, m_cyc == 1});
        chk("partial_rounds", {31'd0, partial_rounds}, {31'd0, rnd});
        chk("update_digest",  {31'd0, update_digest},  {31'd0, m_cyc == 66});
        chk("digest_valid",   {31'd0, digest_valid},   {31'd0, m_cyc == 67});
        chk("first_block",    {31'd0, first_block},    {31'd0, m_first});
        chk("seq_error",      {31'd0, seq_error},      {31'd0, m_err});
        chk("round_idx",      {26'd0, round_idx},      rnd ? 32'(m_cyc - 2) : 32'd0);
        chk("w_data",         w_data,                  rnd ? w_of(m_block, m_cyc - 2) : 32'd0);
        if (digest_valid) dv_count++;
    end

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Offer a block and return #1 after its accept edge (start of cycle 1).
    task automatic offer(input logic [511:0] blk, input logic f, input logic l);
        int guard;
        block_data = blk; block_first = f; block_last = l; block_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!block_ready && guard < 200) begin guard++; @(negedge clk); end
        chk("accept_timeout", {31'd0, block_ready}, 32'd1);
        @(posedge clk); #1;
        block_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!block_ready && guard < 200) begin guard++; @(negedge clk); end
        chk("idle_timeout", {31'd0, block_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [511:0] abc;
        int k, dv0;
        abc = {32'h61626380, 448'd0, 32'h00000018};

        // Reset state
        #2;
        chk("rst_ready", {31'd0, block_ready}, 32'd1);
        chk("rst_w", w_data, 32'd0);
        chk("model_w16", w_of(abc, 16), 32'h61626380);
        chk("model_w17", w_of(abc, 17), 32'h000F0000);
        #20 reset_n = 1'b1;
        @(posedge clk); #1;

        // "abc" single block with literal expectations
        dv0 = dv_count;
        offer(abc, 1'b1, 1'b1);
        for (k = 1; k <= 68; k++) begin
            @(negedge clk);
            if (k == 2)  chk("abc_w0",  w_data, 32'h61626380);
            if (k == 18) chk("abc_w16", w_data, 32'h61626380);
            if (k == 19) chk("abc_w17", w_data, 32'h000F0000);
            if (k == 66) chk("abc_dv66", {31'd0, digest_valid}, 32'd0);
            if (k == 67) chk("abc_dv67", {31'd0, digest_valid}, 32'd1);
            if (k == 68) chk("abc_ready68", {31'd0, block_ready}, 32'd1);
            if (k <= 67) chk("abc_first", {31'd0, first_block}, 32'd1);
            @(posedge clk); #1;
        end

        // Two-block message offered back-to-back
        dv0 = dv_count;
        offer(rand_block(), 1'b1, 1'b0);
        block_data = rand_block(); block_first = 1'b0; block_last = 1'b1; block_valid = 1'b1;
        k = 1;
        @(negedge clk);
        while (!block_ready && k < 200) begin k++; @(negedge clk); end
        chk("b2b_accept_cycle", k, 32'd67);
        @(posedge clk); #1;
        block_valid = 1'b0;
        wait_idle();
        chk("b2b_dv_pulses", dv_count - dv0, 32'd1);

        // Busy offer: changing data ignored while rounds proceed
        offer(rand_block(), 1'b0, 1'b1);
        for (k = 1; k <= 60; k++) begin
            block_valid = 1'b1; block_data = rand_block(); block_first = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k >= 2) chk("busy_round_idx", {26'd0, round_idx}, 32'(k - 2));
            @(posedge clk); #1;
        end
        block_valid = 1'b0;
        wait_idle();

        // Missing update_AH at round 30
        offer(rand_block(), 1'b1, 1'b1);
        repeat (31) @(posedge clk);
        #1 update_AH = 1'b0;
        @(negedge clk);
        chk("drop_round30", {26'd0, round_idx}, 32'd30);
        chk("drop_err_before", {31'd0, seq_error}, 32'd0);
        @(posedge clk); #1 update_AH = 1'b1;
        @(negedge clk);
        chk("drop_err_after", {31'd0, seq_error}, 32'd1);
        wait_idle();
        chk("drop_err_sticky", {31'd0, seq_error}, 32'd1);

        // Reset at round 40, then a normal block
        offer(rand_block(), 1'b1, 1'b1);
        repeat (41) @(posedge clk);
        #1;
        chk("rst_round40", {26'd0, round_idx}, 32'd40);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, block_ready}, 32'd1);
        chk("arst_partial", {31'd0, partial_rounds}, 32'd0);
        chk("arst_idx", {26'd0, round_idx}, 32'd0);
        chk("arst_err", {31'd0, seq_error}, 32'd0);
        chk("arst_first", {31'd0, first_block}, 32'd0);
        @(negedge clk); @(posedge clk); #3 reset_n = 1'b1;
        dv0 = dv_count;
        offer(rand_block(), 1'b1, 1'b1);
        wait_idle();
        chk("post_rst_dv", dv_count - dv0, 32'd1);

        // Schedule sweep with random blocks and flags
        for (int n = 0; n < 8; n++) begin
            offer(rand_block(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
